// File: rtl/pulse_interval_meter.sv
// -----------------------------------------------------------------------------
// pulse_interval_meter
//
// Measures the number of 20 ns clock ticks between a start pulse and a stop
// pulse. Reports the tick count with a one-cycle done pulse, or abandons the
// measurement with a one-cycle tmo pulse once TIMEOUT ticks have elapsed.
//
// Parameters:
//   WIDTH     counter / result width in bits
//   TIMEOUT   tick count at which a measurement is abandoned
//             (1 <= TIMEOUT <= 2**WIDTH-1)
//
// Ports:
//   clk        in   system clock (50 MHz)
//   reset      in   synchronous, active-low reset
//   start      in   pulse: begin or restart a measurement
//   stop       in   pulse: end a running measurement
//   abort      in   pulse: cancel a running measurement, no result
//   clr_stats  in   clear min/max statistics (statistics build only)
//   busy       out  high while measuring
//   count      out  last result, held until next result or timeout
//   done       out  one-cycle pulse, count newly valid
//   tmo        out  one-cycle pulse, measurement timed out
//   min_count  out  smallest completed measurement (statistics build only)
//   max_count  out  largest completed measurement (statistics build only)
//
// Optional feature macro: INTERVAL_METER_STATS_EN builds the min/max
// statistics registers; without it min_count/max_count are tied to 0.
// -----------------------------------------------------------------------------
module pulse_interval_meter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 5000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             abort,
   input  logic             clr_stats,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic             done,
   output logic             tmo,
   output logic [WIDTH-1:0] min_count,
   output logic [WIDTH-1:0] max_count
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [WIDTH-1:0] TMO_VAL = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic             tmo_q, tmo_d;

   // Event priority in RUN: start (retrigger) > abort > stop > timeout.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      count_d = count_q;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               r_d     = ONE;
            end
         end
         S_RUN: begin
            if (start) begin
               r_d = ONE;
            end else if (abort) begin
               state_d = S_IDLE;
               r_d     = '0;
            end else if (stop) begin
               // A stop coinciding with r == TIMEOUT is still a valid result.
               state_d = S_IDLE;
               r_d     = '0;
               count_d = r_q;
               done_d  = 1'b1;
            end else if (r_q == TMO_VAL) begin
               state_d = S_IDLE;
               r_d     = '0;
               count_d = TMO_VAL;
               tmo_d   = 1'b1;
            end else begin
               r_d = r_q + ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            r_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         count_q <= count_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
      end
   end

   assign busy  = (state_q == S_RUN);
   assign count = count_q;
   assign done  = done_q;
   assign tmo   = tmo_q;

`ifdef INTERVAL_METER_STATS_EN
   logic [WIDTH-1:0] min_q, max_q;

   // Statistics follow the result register: they update on the same edge
   // that loads count on a completed measurement (r_q is the new result).
   always_ff @(posedge clk) begin
      if (!reset || clr_stats) begin
         min_q <= '1;
         max_q <= '0;
      end else if (done_d) begin
         if (r_q < min_q) min_q <= r_q;
         if (r_q > max_q) max_q <= r_q;
      end
   end

   assign min_count = min_q;
   assign max_count = max_q;
`else
   logic unused_clr_stats;
   assign unused_clr_stats = clr_stats;
   assign min_count        = '0;
   assign max_count        = '0;
`endif

endmodule

// File: doc/pulse_interval_meter.md
# pulse_interval_meter

Measures the time between a start pulse and a stop pulse in 20 ns clock ticks and reports the count, a done pulse, or a timeout. It is the measuring counterpart of the fixed delay-line modules, which turn one pulse into a later pulse. This block turns a pulse pair back into a tick count. It serves bench loopback checks of delay lines and run-time measurement of processor pulse-chain spacing, e.g. memory cycle start to completion.

## Interface
- WIDTH, 16: counter and result width in bits.
- TIMEOUT, 5000: tick count (100 µs) at which an unfinished measurement is abandoned; must satisfy 1 ≤ TIMEOUT ≤ 2^WIDTH−1.
- clk  input  1  system clock, 50 MHz (20 ns per tick).
- reset  input  1  one clock; reset is synchronous and active-low (reset = 0 resets on the clk rising edge).
- start  input  1  single-cycle pulse; begins (or restarts) a measurement.
- stop  input  1  single-cycle pulse; ends a running measurement.
- abort  input  1  single-cycle pulse; cancels a running measurement with no result.
- busy  output  1  level, high while measuring.
- count  output  WIDTH  last result; held until the next result or timeout.
- done  output  1  one-cycle pulse, count newly valid.
- tmo  output  1  one-cycle pulse, measurement timed out.
- clr_stats  input  1  clears statistics (used only with INTERVAL_METER_STATS_EN).
- min_count, max_count  output  WIDTH  statistics (see Configuration).

## Operation
- Two states: IDLE and RUN. Internal tick register r (WIDTH bits).
- IDLE, start=1 → RUN, r←1. stop and abort are ignored in IDLE.
- RUN, each cycle with no event → r←r+1.
- RUN, stop=1 (start=0) → count←r, done=1 next cycle, go to IDLE, r←0.
- RUN, start=1 → retrigger: r←1, stay in RUN, no done. Start has priority over stop and abort in the same cycle.
- RUN, abort=1 (start=0) → IDLE, r←0, no done, no tmo, count unchanged. Abort has priority over stop.
- RUN, r==TIMEOUT with no stop/start/abort → count←TIMEOUT, tmo=1 next cycle, go to IDLE.
- stop in the same cycle as r==TIMEOUT → valid measurement: done, not tmo, count=TIMEOUT.
- r never wraps; TIMEOUT bounds it.
- busy = (state==RUN), registered.

## Timing
- Reset values: state=IDLE, r=0, busy=0, count=0, done=0, tmo=0, min_count=all-ones, max_count=0.
- Reset asserted mid-RUN aborts the measurement with no done or tmo. Outputs take their reset values on the next edge.
- start sampled at edge E0 and stop at edge Ek gives count=k. busy is high from after E0 through Ek; done and count update after Ek.
- Minimum measurable interval is 1 (stop on the cycle right after start). A DUT delay line that fires when its counter equals N yields count=N.
- done and tmo are never high together and each lasts exactly one cycle.
- A new start is accepted on the same cycle done/tmo is high (state is already IDLE).

## Configuration
- INTERVAL_METER_STATS_EN defined:
  - On each done, min_count←min(min_count,count_new) and max_count←max(max_count,count_new).
  - Timeouts and aborts do not update statistics.
  - clr_stats=1 restores the reset values, with priority over a simultaneous update.
- Not defined: min_count and max_count are driven to constant 0, clr_stats is ignored, and no statistics registers are built.

## Test plan
- Loopback: start pulse feeds a 5-tick delay line whose output drives stop → count=5, done one cycle after stop, busy high exactly 5 cycles.
- start then stop 1 cycle later → count=1. stop alone in IDLE → no done, busy stays 0.
- TIMEOUT=5000, no stop → tmo at 5001 cycles after start, count=5000, done never asserted. Stop landing exactly at r==5000 → done with count=5000, no tmo.
- Retrigger: start at t=0, start at t=7, stop at t=10 → single done with count=3. start+stop in the same IDLE cycle → RUN, no done.
- abort at t=4 after start → busy drops, no done/tmo, count keeps its prior value. Reset=0 at t=3 of a run → all outputs take reset values, no pulses.
- With INTERVAL_METER_STATS_EN: measure 12, 4, 9 → min_count=4, max_count=12. clr_stats → min_count=all-ones, max_count=0. Without the macro, both read 0 throughout.
